// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and default frame width.
// The PARITY state only exists when PISO_PARITY_EN is defined.
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef PISO_PARITY_EN
    SHIFT = 2'd1,
    PARITY = 2'd2
`else
    SHIFT = 2'd1
`endif
  } piso_state_t;

  function automatic int piso_count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the serializer: synchronous clear, count enable, and a
// terminal-count flag raised while the count equals TERMINAL.
module piso_bit_counter #(
  parameter int TERMINAL = 3,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TERMINAL));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready word input and registered serial outputs.
// Optional feature macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = piso_count_width(WIDTH);

  piso_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             tc;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_en;
`ifdef PISO_PARITY_EN
  logic             parity_bit;
`else
  logic             near_last;
`endif

  assign din_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = din_valid && din_ready;
  assign cnt_clear = accept || ((state == SHIFT) && tc);
  assign cnt_en    = (state == SHIFT) && !tc;
`ifndef PISO_PARITY_EN
  // The bit being loaded next is the last data bit, so frame_done goes out with it.
  assign near_last = (count == CW'(WIDTH - 2));
`endif

  // count tracks the index of the bit currently on so; it reaches WIDTH-1 on the last data bit.
  piso_bit_counter #(
    .TERMINAL(WIDTH - 1),
    .CW      (CW)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .en   (cnt_en),
    .count(count),
    .tc   (tc)
  );

  // The first bit is loaded straight from din on the accepting edge, so the
  // shift register only keeps the bits that are still to be sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      so         <= 1'b0;
      so_valid   <= 1'b0;
      frame_done <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SHIFT;
            so         <= LSB_FIRST ? din[0] : din[WIDTH-1];
            shreg      <= LSB_FIRST ? (din >> 1) : (din << 1);
            so_valid   <= 1'b1;
            frame_done <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_bit <= ^din;
`endif
          end else begin
            so         <= 1'b0;
            so_valid   <= 1'b0;
            frame_done <= 1'b0;
          end
        end

        SHIFT: begin
          if (tc) begin
`ifdef PISO_PARITY_EN
            state      <= PARITY;
            so         <= parity_bit;
            so_valid   <= 1'b1;
            frame_done <= 1'b1;
`else
            state      <= IDLE;
            so         <= 1'b0;
            so_valid   <= 1'b0;
            frame_done <= 1'b0;
`endif
          end else begin
            so         <= LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
            shreg      <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
            so_valid   <= 1'b1;
`ifdef PISO_PARITY_EN
            frame_done <= 1'b0;
`else
            frame_done <= near_last;
`endif
          end
        end

`ifdef PISO_PARITY_EN
        PARITY: begin
          state      <= IDLE;
          so         <= 1'b0;
          so_valid   <= 1'b0;
          frame_done <= 1'b0;
        end
`endif

        default: begin
          state      <= IDLE;
          so         <= 1'b0;
          so_valid   <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an LSB-first and an MSB-first instance share stimulus,
// expected bits are queued per instance and popped by monitors whenever so_valid is high.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FLEN   = W + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FLEN   = W;
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;

  logic l_ready, l_so, l_so_valid, l_done, l_busy;
  logic m_ready, m_so, m_so_valid, m_done, m_busy;

  typedef struct packed {
    logic bit_val;
    logic last;
  } exp_t;

  typedef struct {
    logic [3:0] word;
    logic [3:0] lsb_seq;
    logic [3:0] msb_seq;
    logic       par;
  } vec_t;

  // Emission order is packed with the first serial bit in position 0.
  vec_t vecs [5] = '{
    '{4'b1010, 4'b1010, 4'b0101, 1'b0},
    '{4'b0101, 4'b0101, 4'b1010, 1'b0},
    '{4'b0000, 4'b0000, 4'b0000, 1'b0},
    '{4'b1111, 4'b1111, 4'b1111, 1'b0},
    '{4'b1000, 4'b1000, 4'b0001, 1'b1}
  };

  exp_t q_l[$];
  exp_t q_m[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   mon_en     = 1'b0;

  logic [3:0] sipo;
  int         sipo_n;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .so(l_so), .so_valid(l_so_valid), .frame_done(l_done), .busy(l_busy)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .so(m_so), .so_valid(m_so_valid), .frame_done(m_done), .busy(m_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic pushExpected(input logic [3:0] lsb_seq, input logic [3:0] msb_seq,
                              input logic par, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      q_l.push_back('{lsb_seq[i], (i == W - 1) && !PAR_EN});
      q_m.push_back('{msb_seq[i], (i == W - 1) && !PAR_EN});
    end
    if (PAR_EN && nbits == W) begin
      q_l.push_back('{par, 1'b1});
      q_m.push_back('{par, 1'b1});
    end
  endtask

  // Offers a word for one accepting edge, then scrambles din while the frame is in flight.
  task automatic applyStimulus(input logic [3:0] word, input logic [3:0] lsb_seq,
                               input logic [3:0] msb_seq, input logic par);
    int n = 0;
    while (l_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) checkOutput("ready_timeout", 32'd0, 32'd1);
    din       = word;
    din_valid = 1'b1;
    pushExpected(lsb_seq, msb_seq, par, W);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = ~word;
    checkOutput("busy_after_accept", {31'd0, l_busy}, 32'd1);
  endtask

  always @(negedge clk) begin : mon_lsb
    exp_t e;
    if (mon_en) begin
      if (l_so_valid === 1'b1) begin
        if (q_l.size() == 0) begin
          checkOutput("lsb_unexpected_bit", 32'd1, 32'd0);
        end else begin
          e = q_l.pop_front();
          checkOutput("lsb_so", {31'd0, l_so}, {31'd0, e.bit_val});
          checkOutput("lsb_frame_done", {31'd0, l_done}, {31'd0, e.last});
        end
      end else begin
        checkOutput("lsb_idle_outputs", {30'd0, l_so, l_done}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon_msb
    exp_t e;
    if (mon_en) begin
      if (m_so_valid === 1'b1) begin
        if (q_m.size() == 0) begin
          checkOutput("msb_unexpected_bit", 32'd1, 32'd0);
        end else begin
          e = q_m.pop_front();
          checkOutput("msb_so", {31'd0, m_so}, {31'd0, e.bit_val});
          checkOutput("msb_frame_done", {31'd0, m_done}, {31'd0, e.last});
        end
      end else begin
        checkOutput("msb_idle_outputs", {30'd0, m_so, m_done}, 32'd0);
      end
    end
  end

  // Downstream 4-bit SIPO (MSB-in, shift-right) fed by the LSB-first data bits only.
  always @(posedge clk) begin
    if (rst) begin
      sipo   <= 4'd0;
      sipo_n <= 0;
    end else if (l_so_valid && sipo_n < W) begin
      sipo   <= {l_so, sipo[3:1]};
      sipo_n <= sipo_n + 1;
    end else if (!l_so_valid) begin
      sipo_n <= 0;
    end
  end

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_so_valid", {31'd0, l_so_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, l_busy}, 32'd0);
    checkOutput("reset_frame_done", {31'd0, l_done}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    checkOutput("ready_after_reset", {30'd0, l_ready, m_ready}, 32'd3);

    $display("[TB] single frame 4'b1011");
    applyStimulus(4'b1011, 4'b1011, 4'b1101, 1'b1);
    checkOutput("ready_low_in_frame", {31'd0, l_ready}, 32'd0);
    repeat (FLEN) @(posedge clk);
    #1;
    checkOutput("ready_after_frame", {31'd0, l_ready}, 32'd1);
    checkOutput("busy_after_frame", {31'd0, l_busy}, 32'd0);
    checkOutput("sipo_word", {28'd0, sipo}, 32'hB);

    $display("[TB] directed vector table");
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].word, vecs[k].lsb_seq, vecs[k].msb_seq, vecs[k].par);
      repeat (FLEN) @(posedge clk);
      #1;
    end

    $display("[TB] back-to-back frames with din_valid held high");
    din       = 4'hA;
    din_valid = 1'b1;
    pushExpected(4'b1010, 4'b0101, 1'b0, W);
    @(posedge clk);
    #1;
    din = 4'hF;
    repeat (FLEN) @(posedge clk);
    #1;
    checkOutput("gap_so_valid", {31'd0, l_so_valid}, 32'd0);
    checkOutput("gap_ready", {31'd0, l_ready}, 32'd1);
    din = 4'h5;
    pushExpected(4'b0101, 4'b1010, 1'b0, W);
    @(posedge clk);
    #1;
    checkOutput("second_frame_started", {31'd0, l_so_valid}, 32'd1);
    din_valid = 1'b0;
    repeat (FLEN) @(posedge clk);
    #1;

    $display("[TB] reset mid-frame");
    din       = 4'b1011;
    din_valid = 1'b1;
    pushExpected(4'b1011, 4'b1101, 1'b1, 2);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_so_valid", {31'd0, l_so_valid}, 32'd0);
    checkOutput("abort_busy", {30'd0, l_busy, m_busy}, 32'd0);
    rst = 1'b0;
    checkOutput("abort_ready", {31'd0, l_ready}, 32'd1);
    applyStimulus(4'b0110, 4'b0110, 4'b0110, 1'b0);
    repeat (FLEN) @(posedge clk);
    #1;

    $display("[TB] reset coincident with din_valid");
    rst       = 1'b1;
    din       = 4'b1111;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    din_valid = 1'b0;
    checkOutput("rst_priority_busy", {31'd0, l_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    if (PAR_EN) begin
      $display("[TB] parity of 4'b0000");
      applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
      repeat (FLEN) @(posedge clk);
      #1;
    end

    for (int t = 0; t < 20 && (q_l.size() != 0 || q_m.size() != 0); t++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("lsb_queue_drained", q_l.size(), 32'd0);
    checkOutput("msb_queue_drained", q_m.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4, frame data width in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1, serial bit order: 1 = din[0] first, 0 = din[WIDTH-1] first.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port din  input  WIDTH  parallel word to serialize.
REQ-006 Port din_valid  input  1  upstream asserts that din holds a word.
REQ-007 Port din_ready  output  1  block can accept a word this cycle.
REQ-008 Port so  output  1  serial data out; feeds the downstream SIPO serial input.
REQ-009 Port so_valid  output  1  so carries a frame bit this cycle.
REQ-010 Port frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.
REQ-011 Port busy  output  1  high while a frame is in flight (state != IDLE).

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and PARITY (PARITY only with PISO_PARITY_EN).
REQ-013 A word SHALL be accepted on a rising edge where din_valid && din_ready; din_ready SHALL equal (state == IDLE).
REQ-014 On acceptance din SHALL be captured into an internal WIDTH-bit shift register and the FSM SHALL move IDLE -> SHIFT.
REQ-015 Latency: the first bit SHALL appear on so with so_valid=1 in the cycle immediately after the accepting edge.
REQ-016 In SHIFT, so SHALL present one bit per cycle for exactly WIDTH consecutive cycles, order per LSB_FIRST, so_valid held at 1 throughout.
REQ-017 A bit counter of width $clog2(WIDTH+1) SHALL count bits sent; SHIFT -> IDLE (or -> PARITY) when count reaches WIDTH-1 on the current bit.
REQ-018 frame_done SHALL pulse for exactly one cycle with the final frame bit (last data bit, or parity bit when enabled).
REQ-019 din and din_valid SHALL be ignored while busy; changes to din mid-frame SHALL NOT alter the bits sent.
REQ-020 In IDLE, so and so_valid SHALL be 0; minimum gap between frames SHALL be one IDLE cycle.
REQ-021 din_valid held high continuously SHALL yield back-to-back frames separated by exactly one idle cycle.

Reset
REQ-022 rst=1 SHALL, at the next rising edge, force state=IDLE, shift register=0, counter=0, so=0, so_valid=0, frame_done=0, busy=0; din_ready SHALL be 1 in the first cycle after reset is released.
REQ-023 Reset asserted mid-frame SHALL abort the frame: no further bits and no frame_done pulse for that frame.
REQ-024 rst coincident with din_valid SHALL take priority; the word SHALL NOT be accepted.

Configuration
REQ-025 Macro PISO_PARITY_EN defined: after the WIDTH data bits, one PARITY cycle SHALL output the even-parity bit (XOR of the captured word) with so_valid=1 and frame_done=1; frame length is WIDTH+1.
REQ-026 Macro PISO_PARITY_EN undefined: the PARITY state and parity logic SHALL NOT exist; frame length is WIDTH, frame_done with the last data bit.

Structure
REQ-027 Package piso_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, PARITY) and the default WIDTH constant.
REQ-028 The bit counter SHALL be a sub-module piso_bit_counter (synchronous clear, enable, terminal-count output); all other logic stays in piso_serializer.

Verification
REQ-029 WIDTH=4, LSB_FIRST=1, din=4'b1011 accepted at edge N -> so=1,1,0,1 in cycles N+1..N+4, so_valid=1 for those four cycles, frame_done only at N+4, din_ready=1 again at N+5.
REQ-030 Same word with LSB_FIRST=0 -> so=1,0,1,1; a downstream 4-bit SIPO (MSB-in, shift-right) fed from LSB_FIRST=1 output SHALL hold 4'b1011 after the fourth bit.
REQ-031 din_valid held high with words 4'hA then 4'h5 -> two frames with exactly one idle cycle between them; din changed mid-frame -> no effect on the bits sent.
REQ-032 rst asserted in cycle N+2 of a frame -> so_valid=0 and busy=0 from the following cycle; no frame_done; next word serialized correctly.
REQ-033 PISO_PARITY_EN defined, din=4'b1011 -> data bits followed by parity bit 1 at N+5, frame_done at N+5 only; din=4'b0000 -> parity bit 0.
